// File: rtl/axi_id_remap_narrow.sv
// AXI ID narrowing remapper: wide slave-port IDs are mapped onto a small table of narrow
// master-port IDs per direction, and original IDs are restored on B/R responses.
package axi_id_remap_narrow_pkg;
  localparam int unsigned SlvIdWidth = 6;
  localparam int unsigned MstIdWidth = 2;
  localparam int unsigned AddrWidth  = 32;
  localparam int unsigned DataWidth  = 32;
  localparam int unsigned LenWidth   = 8;
  localparam int unsigned StrbWidth  = DataWidth / 8;

  typedef struct packed {
    logic [SlvIdWidth-1:0] id;
    logic [AddrWidth-1:0]  addr;
    logic [LenWidth-1:0]   len;
  } nar_slv_ax_t;

  typedef struct packed {
    logic [MstIdWidth-1:0] id;
    logic [AddrWidth-1:0]  addr;
    logic [LenWidth-1:0]   len;
  } nar_mst_ax_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
    logic                 last;
  } nar_w_t;

  typedef struct packed {
    logic [SlvIdWidth-1:0] id;
    logic [1:0]            resp;
  } nar_slv_b_t;

  typedef struct packed {
    logic [MstIdWidth-1:0] id;
    logic [1:0]            resp;
  } nar_mst_b_t;

  typedef struct packed {
    logic [SlvIdWidth-1:0] id;
    logic [DataWidth-1:0]  data;
    logic [1:0]            resp;
    logic                  last;
  } nar_slv_r_t;

  typedef struct packed {
    logic [MstIdWidth-1:0] id;
    logic [DataWidth-1:0]  data;
    logic [1:0]            resp;
    logic                  last;
  } nar_mst_r_t;
endpackage

module axi_id_remap_narrow
  import axi_id_remap_narrow_pkg::*;
#(
  parameter int unsigned AxiIdWidthSlvPort = 6,
  parameter int unsigned AxiIdWidthMstPort = 2,
  parameter int unsigned MaxTxnsPerId      = 4,
  parameter type slv_aw_chan_t = nar_slv_ax_t,
  parameter type slv_w_chan_t  = nar_w_t,
  parameter type slv_b_chan_t  = nar_slv_b_t,
  parameter type slv_ar_chan_t = nar_slv_ax_t,
  parameter type slv_r_chan_t  = nar_slv_r_t,
  parameter type mst_aw_chan_t = nar_mst_ax_t,
  parameter type mst_w_chan_t  = nar_w_t,
  parameter type mst_b_chan_t  = nar_mst_b_t,
  parameter type mst_ar_chan_t = nar_mst_ax_t,
  parameter type mst_r_chan_t  = nar_mst_r_t
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  slv_aw_chan_t slv_aw_chan_i,
  input  logic         slv_aw_valid_i,
  output logic         slv_aw_ready_o,
  input  slv_w_chan_t  slv_w_chan_i,
  input  logic         slv_w_valid_i,
  output logic         slv_w_ready_o,
  output slv_b_chan_t  slv_b_chan_o,
  output logic         slv_b_valid_o,
  input  logic         slv_b_ready_i,
  input  slv_ar_chan_t slv_ar_chan_i,
  input  logic         slv_ar_valid_i,
  output logic         slv_ar_ready_o,
  output slv_r_chan_t  slv_r_chan_o,
  output logic         slv_r_valid_o,
  input  logic         slv_r_ready_i,
  output mst_aw_chan_t mst_aw_chan_o,
  output logic         mst_aw_valid_o,
  input  logic         mst_aw_ready_i,
  output mst_w_chan_t  mst_w_chan_o,
  output logic         mst_w_valid_o,
  input  logic         mst_w_ready_i,
  input  mst_b_chan_t  mst_b_chan_i,
  input  logic         mst_b_valid_i,
  output logic         mst_b_ready_o,
  output mst_ar_chan_t mst_ar_chan_o,
  output logic         mst_ar_valid_o,
  input  logic         mst_ar_ready_i,
  input  mst_r_chan_t  mst_r_chan_i,
  input  logic         mst_r_valid_i,
  output logic         mst_r_ready_o
);
  localparam int unsigned CntWidth = $clog2(MaxTxnsPerId + 1);
  localparam int unsigned NoIds    = 2 ** AxiIdWidthMstPort;
  localparam int unsigned NoDirs   = 2;
  localparam int unsigned DirW     = 0;
  localparam int unsigned DirR     = 1;

  typedef logic [AxiIdWidthSlvPort-1:0] wide_id_t;
  typedef logic [AxiIdWidthMstPort-1:0] narrow_id_t;
  typedef logic [CntWidth-1:0]          cnt_t;

  wide_id_t   orig_q [NoDirs][NoIds];
  wide_id_t   orig_d [NoDirs][NoIds];
  cnt_t       cnt_q  [NoDirs][NoIds];
  cnt_t       cnt_d  [NoDirs][NoIds];

  wide_id_t   req_id     [NoDirs];
  logic       req_hs     [NoDirs];
  logic       ok_c       [NoDirs];
  narrow_id_t idx_c      [NoDirs];
  narrow_id_t rsp_idx    [NoDirs];
  logic       rsp_dec    [NoDirs];

  assign req_id[DirW]  = slv_aw_chan_i.id;
  assign req_id[DirR]  = slv_ar_chan_i.id;
  assign req_hs[DirW]  = slv_aw_valid_i & mst_aw_ready_i & ok_c[DirW];
  assign req_hs[DirR]  = slv_ar_valid_i & mst_ar_ready_i & ok_c[DirR];
  assign rsp_idx[DirW] = mst_b_chan_i.id;
  assign rsp_idx[DirR] = mst_r_chan_i.id;
  assign rsp_dec[DirW] = mst_b_valid_i & slv_b_ready_i;
  assign rsp_dec[DirR] = mst_r_valid_i & slv_r_ready_i & mst_r_chan_i.last;

  // Lookup: an existing entry for the ID wins (stall if full), else lowest free entry.
  always_comb begin : lookup
    logic       hit, hit_full, free_found;
    narrow_id_t hit_idx, free_idx;
    hit        = 1'b0;
    hit_full   = 1'b0;
    free_found = 1'b0;
    hit_idx    = '0;
    free_idx   = '0;
    for (int d = 0; d < NoDirs; d++) begin
      hit        = 1'b0;
      hit_full   = 1'b0;
      free_found = 1'b0;
      hit_idx    = '0;
      free_idx   = '0;
      for (int i = 0; i < NoIds; i++) begin
        if (cnt_q[d][i] != '0 && orig_q[d][i] == req_id[d]) begin
          hit      = 1'b1;
          hit_idx  = narrow_id_t'(i);
          hit_full = (cnt_q[d][i] == cnt_t'(MaxTxnsPerId));
        end
        if (cnt_q[d][i] == '0 && !free_found) begin
          free_found = 1'b1;
          free_idx   = narrow_id_t'(i);
        end
      end
      ok_c[d]  = hit ? !hit_full : free_found;
      idx_c[d] = hit ? hit_idx : free_idx;
    end
  end

  always_comb begin : table_next
    logic inc_i, dec_i;
    orig_d = orig_q;
    cnt_d  = cnt_q;
    inc_i  = 1'b0;
    dec_i  = 1'b0;
    for (int d = 0; d < NoDirs; d++) begin
      for (int i = 0; i < NoIds; i++) begin
        inc_i = req_hs[d] && (idx_c[d] == narrow_id_t'(i));
        dec_i = rsp_dec[d] && (rsp_idx[d] == narrow_id_t'(i));
        if (inc_i) orig_d[d][i] = req_id[d];
        cnt_d[d][i] = cnt_q[d][i] + cnt_t'(inc_i) - cnt_t'(dec_i);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int d = 0; d < NoDirs; d++) begin
        for (int i = 0; i < NoIds; i++) begin
          orig_q[d][i] <= '0;
          cnt_q[d][i]  <= '0;
        end
      end
    end else begin
      orig_q <= orig_d;
      cnt_q  <= cnt_d;
    end
  end

  assign mst_aw_valid_o = slv_aw_valid_i & ok_c[DirW];
  assign slv_aw_ready_o = mst_aw_ready_i & ok_c[DirW];
  assign mst_aw_chan_o  = '{id: idx_c[DirW], addr: slv_aw_chan_i.addr, len: slv_aw_chan_i.len};

  assign mst_ar_valid_o = slv_ar_valid_i & ok_c[DirR];
  assign slv_ar_ready_o = mst_ar_ready_i & ok_c[DirR];
  assign mst_ar_chan_o  = '{id: idx_c[DirR], addr: slv_ar_chan_i.addr, len: slv_ar_chan_i.len};

  assign mst_w_chan_o   = slv_w_chan_i;
  assign mst_w_valid_o  = slv_w_valid_i;
  assign slv_w_ready_o  = mst_w_ready_i;

  assign slv_b_chan_o   = '{id: orig_q[DirW][rsp_idx[DirW]], resp: mst_b_chan_i.resp};
  assign slv_b_valid_o  = mst_b_valid_i;
  assign mst_b_ready_o  = slv_b_ready_i;

  assign slv_r_chan_o   = '{id: orig_q[DirR][rsp_idx[DirR]], data: mst_r_chan_i.data,
                            resp: mst_r_chan_i.resp, last: mst_r_chan_i.last};
  assign slv_r_valid_o  = mst_r_valid_i;
  assign mst_r_ready_o  = slv_r_ready_i;

`ifndef SYNTHESIS
  if (AxiIdWidthMstPort >= AxiIdWidthSlvPort) begin : gen_bad_id_width
    $fatal(1, "AxiIdWidthMstPort must be smaller than AxiIdWidthSlvPort");
  end
  if (MaxTxnsPerId < 1) begin : gen_bad_max_txns
    $fatal(1, "MaxTxnsPerId must be at least 1");
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      for (int d = 0; d < NoDirs; d++) begin
        assert (!(rsp_dec[d] && cnt_q[d][rsp_idx[d]] == '0))
          else $error("response to a free entry (counter underflow), dir %0d", d);
        assert (!(req_hs[d] && cnt_q[d][idx_c[d]] == cnt_t'(MaxTxnsPerId)))
          else $error("counter overflow, dir %0d", d);
      end
    end
  end
`endif
endmodule
